// File: rtl/store_op_pkg.sv
// Shared constants and sizing helper for the store operator.
package store_op_pkg;

  localparam int MaxStoreLatency = 9;
  localparam int MaxBufferDepth  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Synchronous FIFO whose head entry is held in a dedicated register.
module store_fifo
  import store_op_pkg::*;
#(
  parameter int Width = 64,
  parameter int Depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [Width-1:0]      din,
  output logic [Width-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(Depth):0] count
);

  localparam int PW = clog2(Depth);
  localparam int CW = PW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [Width-1:0] head_d;
  logic             do_push, do_pop;

  assign full    = (count == CW'(Depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The head register is loaded with whatever will sit at the read pointer
  // next cycle; a push into an otherwise-drained FIFO bypasses the array.
  always_comb begin
    rd_nxt  = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    cnt_nxt = count;
    if (do_push && !do_pop)      cnt_nxt = count + CW'(1);
    else if (do_pop && !do_push) cnt_nxt = count - CW'(1);
    head_d = head;
    if (cnt_nxt != '0) begin
      if (do_push && (wr_ptr == rd_nxt)) head_d = din;
      else                               head_d = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      count  <= cnt_nxt;
      head   <= head_d;
    end
  end

endmodule

// File: rtl/store_op.sv
// Store operator: buffers store requests and issues them to a memory write
// port with ready/valid backpressure, pulsing done a fixed delay after each write.
module store_op
  import store_op_pkg::*;
#(
  parameter int ParamBitWidth = 32,
  parameter int AddrWidth     = 32,
  parameter int BufferDepth   = 4,
  parameter int StoreLatency  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [AddrWidth-1:0]     addr,
  input  logic [ParamBitWidth-1:0] wdata,
  output logic                     stall,
  output logic                     mem_wen,
  output logic [AddrWidth-1:0]     mem_addr,
  output logic [ParamBitWidth-1:0] mem_wdata,
  input  logic                     mem_wready,
  output logic                     done,
  output logic                     idle,
  output logic                     overflow
);

  localparam int W  = AddrWidth + ParamBitWidth;
  localparam int CW = clog2(BufferDepth) + 1;
  localparam logic [MaxStoreLatency:1] LatMask = MaxStoreLatency'((1 << StoreLatency) - 1);

  if (StoreLatency < 1 || StoreLatency > MaxStoreLatency) begin : g_bad_latency
    $error("store_op: StoreLatency out of range");
  end
  if (BufferDepth < 2 || BufferDepth > MaxBufferDepth ||
      (BufferDepth & (BufferDepth - 1)) != 0) begin : g_bad_depth
    $error("store_op: BufferDepth must be a power of two in 2..16");
  end

  logic [W-1:0]               head;
  logic                       full, empty, hs, push;
  logic [CW-1:0]              count;
  logic [MaxStoreLatency:1]   hs_d;

  assign mem_wen   = !empty;
  assign hs        = mem_wen && mem_wready;
  assign push      = enable && (!full || hs);
  assign mem_addr  = head[W-1:ParamBitWidth];
  assign mem_wdata = head[ParamBitWidth-1:0];
  assign stall     = (count == CW'(BufferDepth));
  assign done      = hs_d[StoreLatency];
  assign idle      = empty && ((hs_d & LatMask) == '0);

  store_fifo #(
    .Width(W),
    .Depth(BufferDepth)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (hs),
    .din  ({addr, wdata}),
    .head (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d     <= '0;
      overflow <= 1'b0;
    end else begin
      hs_d <= {hs_d[MaxStoreLatency-1:1], hs};
      if (enable && full && !hs) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_store_op.sv
// Directed bench for store_op: table-driven cycle vectors plus reset and latency sequences.
module tb_store_op;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_wready = 1'b0;

  logic        stall1, wen1, done1, idle1, ovf1;
  logic [31:0] maddr1, mdata1;
  logic        stall9, wen9, done9, idle9, ovf9;
  logic [31:0] maddr9, mdata9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_op #(.ParamBitWidth(32), .AddrWidth(32), .BufferDepth(4), .StoreLatency(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .addr(addr), .wdata(wdata),
    .stall(stall1), .mem_wen(wen1), .mem_addr(maddr1), .mem_wdata(mdata1),
    .mem_wready(mem_wready), .done(done1), .idle(idle1), .overflow(ovf1)
  );

  store_op #(.ParamBitWidth(32), .AddrWidth(32), .BufferDepth(4), .StoreLatency(9)) u_dut9 (
    .clk(clk), .rst(rst), .enable(enable), .addr(addr), .wdata(wdata),
    .stall(stall9), .mem_wen(wen9), .mem_addr(maddr9), .mem_wdata(mdata9),
    .mem_wready(mem_wready), .done(done9), .idle(idle9), .overflow(ovf9)
  );

  typedef struct {
    logic        en;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic        wen;
    logic        chkd;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        dn;
    logic        st;
    logic        idl;
    logic        ov;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic [31:0] a, input logic [31:0] d, input logic rdy,
                     input logic wen, input logic chkd, input logic [31:0] ea, input logic [31:0] ed,
                     input logic dn, input logic st, input logic idl, input logic ov);
    vec_t v;
    v.en = en; v.a = a; v.d = d; v.rdy = rdy;
    v.wen = wen; v.chkd = chkd; v.ea = ea; v.ed = ed;
    v.dn = dn; v.st = st; v.idl = idl; v.ov = ov;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each vector: inputs for this cycle, expected outputs observed in this cycle.
    //   en a     d          rdy  wen chkd ea    ed         done stall idle ovf
    // single store
    add(1, 'h10, 'hDEADBEEF, 1,   0, 1, 'h0,  'h0,       0, 0, 1, 0);
    add(0, 0,    0,          1,   1, 1, 'h10, 'hDEADBEEF, 0, 0, 0, 0);
    add(0, 0,    0,          1,   0, 0, 0,    0,         1, 0, 0, 0);
    add(0, 0,    0,          1,   0, 0, 0,    0,         0, 0, 1, 0);
    // backpressure: 5 cycles of wready low
    add(1, 'h1,  'hA,        0,   0, 0, 0,    0,         0, 0, 1, 0);
    add(1, 'h2,  'hB,        0,   1, 1, 'h1,  'hA,       0, 0, 0, 0);
    add(1, 'h3,  'hC,        0,   1, 1, 'h1,  'hA,       0, 0, 0, 0);
    add(0, 0,    0,          0,   1, 1, 'h1,  'hA,       0, 0, 0, 0);
    add(0, 0,    0,          0,   1, 1, 'h1,  'hA,       0, 0, 0, 0);
    add(0, 0,    0,          1,   1, 1, 'h1,  'hA,       0, 0, 0, 0);
    add(0, 0,    0,          1,   1, 1, 'h2,  'hB,       1, 0, 0, 0);
    add(0, 0,    0,          1,   1, 1, 'h3,  'hC,       1, 0, 0, 0);
    add(0, 0,    0,          1,   0, 0, 0,    0,         1, 0, 0, 0);
    add(0, 0,    0,          0,   0, 0, 0,    0,         0, 0, 1, 0);
    // fill to 4, then full + pop + enable
    add(1, 'h21, 'h31,       0,   0, 0, 0,    0,         0, 0, 1, 0);
    add(1, 'h22, 'h32,       0,   1, 1, 'h21, 'h31,      0, 0, 0, 0);
    add(1, 'h23, 'h33,       0,   1, 1, 'h21, 'h31,      0, 0, 0, 0);
    add(1, 'h24, 'h34,       0,   1, 1, 'h21, 'h31,      0, 0, 0, 0);
    add(1, 'h5,  'hE,        1,   1, 1, 'h21, 'h31,      0, 1, 0, 0);
    add(0, 0,    0,          0,   1, 1, 'h22, 'h32,      1, 1, 0, 0);
    // full, no pop: request dropped
    add(1, 'h26, 'h36,       0,   1, 1, 'h22, 'h32,      0, 1, 0, 0);
    add(0, 0,    0,          1,   1, 1, 'h22, 'h32,      0, 1, 0, 1);
    add(0, 0,    0,          1,   1, 1, 'h23, 'h33,      1, 0, 0, 1);
    add(0, 0,    0,          1,   1, 1, 'h24, 'h34,      1, 0, 0, 1);
    add(0, 0,    0,          1,   1, 1, 'h5,  'hE,       1, 0, 0, 1);
    add(0, 0,    0,          1,   0, 0, 0,    0,         1, 0, 0, 1);
    add(0, 0,    0,          0,   0, 0, 0,    0,         0, 0, 1, 1);

    // reset values (reset asserted from time 0)
    #1;
    chk("rst_wen", 32'(wen1), 0);
    chk("rst_addr", maddr1, 0);
    chk("rst_wdata", mdata1, 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_stall", 32'(stall1), 0);
    chk("rst_idle", 32'(idle1), 1);
    chk("rst_ovf", 32'(ovf1), 0);
    tick();
    tick();
    rst = 1'b0;

    foreach (vq[i]) begin
      enable = vq[i].en; addr = vq[i].a; wdata = vq[i].d; mem_wready = vq[i].rdy;
      chk($sformatf("v%0d_wen", i), 32'(wen1), 32'(vq[i].wen));
      if (vq[i].chkd) begin
        chk($sformatf("v%0d_addr", i), maddr1, vq[i].ea);
        chk($sformatf("v%0d_wdata", i), mdata1, vq[i].ed);
      end
      chk($sformatf("v%0d_done", i), 32'(done1), 32'(vq[i].dn));
      chk($sformatf("v%0d_stall", i), 32'(stall1), 32'(vq[i].st));
      chk($sformatf("v%0d_idle", i), 32'(idle1), 32'(vq[i].idl));
      chk($sformatf("v%0d_ovf", i), 32'(ovf1), 32'(vq[i].ov));
      tick();
    end

    // reset mid-operation: two entries buffered, one done pending
    enable = 1; addr = 'h41; wdata = 'h51; mem_wready = 0;
    tick();
    addr = 'h42; wdata = 'h52;
    tick();
    addr = 'h43; wdata = 'h53; mem_wready = 1;
    tick();
    enable = 0; mem_wready = 0;
    chk("mid_pre_wen", 32'(wen1), 1);
    chk("mid_pre_done", 32'(done1), 1);
    chk("mid_pre_ovf", 32'(ovf1), 1);
    rst = 1'b1;
    #1;
    chk("mid_async_wen", 32'(wen1), 0);
    chk("mid_async_done", 32'(done1), 0);
    tick();
    rst = 1'b0;
    mem_wready = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mid_post%0d_wen", k), 32'(wen1), 0);
      chk($sformatf("mid_post%0d_done", k), 32'(done1), 0);
      chk($sformatf("mid_post%0d_idle", k), 32'(idle1), 1);
      chk($sformatf("mid_post%0d_ovf", k), 32'(ovf1), 0);
      chk($sformatf("mid_post%0d_stall", k), 32'(stall1), 0);
      tick();
    end

    // latency sweep on the StoreLatency=9 instance
    enable = 1; addr = 'h60; wdata = 'h70; mem_wready = 1;
    chk("lat_idle_start", 32'(idle9), 1);
    tick();
    enable = 0;
    chk("lat_hs_wen", 32'(wen9), 1);
    chk("lat_hs_addr", maddr9, 'h60);
    chk("lat_hs_wdata", mdata9, 'h70);
    for (int k = 0; k <= 11; k++) begin
      chk($sformatf("lat_n%0d_done", k), 32'(done9), 32'(k == 9));
      chk($sformatf("lat_n%0d_idle", k), 32'(idle9), 32'(k >= 10));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/store_op.md
# store_op

Memory-store datapath operator: the write-side counterpart of the load operator. It accepts store requests (address and data) from the scheduled datapath, buffers them in a small FIFO, and presents them to a synchronous memory write port with ready/valid backpressure. It signals per-store completion a fixed number of cycles after the memory accepts each write, and reports when all stores have drained. It sits between generated datapath operators and the memory/bus write interface.

## Interface
- ParamBitWidth, 32, data width
- AddrWidth, 32, address width
- BufferDepth, 4, FIFO entries; power of two, 2..16
- StoreLatency, 1, cycles from write handshake to `done` pulse; legal range 1..9
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; **asynchronous, active-high**
- enable  in  1  store request this cycle
- addr  in  AddrWidth  store address, sampled with `enable`
- wdata  in  ParamBitWidth  store data, sampled with `enable`
- stall  out  1  buffer full; datapath must not assert `enable`
- mem_wen  out  1  write valid to memory
- mem_addr  out  AddrWidth  write address
- mem_wdata  out  ParamBitWidth  write data
- mem_wready  in  1  memory accepts the write this cycle
- done  out  1  one-cycle pulse per completed store
- idle  out  1  FIFO empty and no completions pending
- overflow  out  1  sticky error: request dropped while full

## Operation
- Push: the FIFO stores {addr, wdata} when `enable` is high and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Drop: when `enable` is high, the FIFO is full, and there is no pop, the request is discarded and `overflow` is set. `overflow` clears only on `rst`.
- Issue: `mem_wen` = FIFO not empty. `mem_addr`/`mem_wdata` = the head entry, driven from registers. They hold stable while `mem_wen` is high and `mem_wready` is low.
- Pop: occurs on `mem_wen && mem_wready`. The next entry is presented in the following cycle. Push and pop in the same cycle leave the occupancy unchanged.
- Order: writes reach memory strictly in request order. There is no merging and no reordering.
- Completion: a shift register `hs_d[9:1]`, with `hs_d[1]` <= handshake and `hs_d[k]` <= `hs_d[k-1]`. `done` = `hs_d[StoreLatency]`. Back-to-back handshakes give back-to-back `done` pulses.
- `stall` = occupancy == BufferDepth (registered count compare). It does not account for a same-cycle pop.
- `idle` = FIFO empty and `hs_d[StoreLatency:1]` all zero.
- Occupancy counter width is clog2(BufferDepth)+1. Read and write pointers are clog2(BufferDepth) bits and wrap naturally.

## Timing
- Reset values: `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `stall`=0, `idle`=1, `overflow`=0. FIFO pointers and count are 0, and `hs_d`=0.
- Latency: `enable` in cycle N gives `mem_wen`=1 in cycle N+1 at the earliest. There is no combinational bypass.
- With `mem_wready` held high, a handshake in cycle N+1 produces `done` in cycle N+1+StoreLatency.
- Throughput: one store per cycle sustained when `mem_wready` is held high.
- Full plus pop plus enable in the same cycle: the request is accepted and `overflow` does not set.
- Empty plus enable: no handshake is possible in that cycle, so `mem_wen` was 0.
- Reset mid-operation: all buffered entries are discarded and pending `done` pulses are cancelled. `mem_wen` drops immediately (asynchronously).
- `mem_wready` asserted while `mem_wen`=0 is ignored.

## Structure
- Package `store_op_pkg`:
  - `MaxStoreLatency = 9`
  - `MaxBufferDepth = 16`
  - a function returning clog2 for pointer sizing
- Parameter legality is checked with elaboration-time assertions against the package constants.
- Sub-module `store_fifo`: synchronous FIFO with registered head output, `push`/`pop`/`full`/`empty`/`count`, width AddrWidth+ParamBitWidth.
- The top level holds the drop/overflow logic, the handshake shift register, and `idle`.

## Test plan
- **Single store:** `enable`, addr=0x10, wdata=0xDEADBEEF, `mem_wready`=1, StoreLatency=1.
  - `mem_wen` high one cycle later with the same addr and data.
  - `done` one cycle after that; `idle` returns to 1.
- **Backpressure:** push 3 stores (0x1/0xA, 0x2/0xB, 0x3/0xC) with `mem_wready`=0 for 5 cycles.
  - The head holds 0x1/0xA stable throughout.
  - After release, writes appear in order on 3 consecutive cycles, followed by 3 consecutive `done` pulses.
- **Full and overflow:** BufferDepth=4, `mem_wready`=0, 5 consecutive `enable`s.
  - `stall`=1 after the 4th push.
  - The 5th request is dropped and `overflow`=1.
  - Draining yields exactly 4 writes.
- **Full with simultaneous pop:** full FIFO; in one cycle, `mem_wready`=1 and `enable` with 0x5/0xE.
  - Request accepted, occupancy stays 4, `overflow` stays 0.
  - 0x5/0xE is written last.
- **Latency sweep:** StoreLatency=9, handshake in cycle N.
  - `done` pulses exactly in cycle N+9.
  - `idle`=0 in cycles N+1..N+8.
- **Reset mid-operation:** 2 entries buffered and 1 `done` pending; assert `rst`.
  - `mem_wen`=0 immediately and no `done` pulse afterward.
  - `idle`=1 and `overflow`=0 after release.
